// File: rtl/ha_result_accumulator.sv
// Accumulates {carry,sum} half-adder results over a run of N_SAMPLES accepted samples.
// Optional feature macro: ACC_SAT_EN (accumulator clamps to all-ones on overflow instead of wrapping).
module ha_result_accumulator #(
   parameter  int ACC_W     = 8,
   parameter  int N_SAMPLES = 16,
   localparam int CNT_W     = $clog2(N_SAMPLES + 1)
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             ena,
   input  logic             start,
   input  logic             clr,
   input  logic             in_valid,
   input  logic             in_sum,
   input  logic             in_carry,
   output logic [ACC_W-1:0] acc_out,
   output logic [CNT_W-1:0] count,
   output logic             busy,
   output logic             done,
   output logic             ovf,
   output logic             err
);

   localparam logic [1:0] IDLE  = 2'd0;
   localparam logic [1:0] ACCUM = 2'd1;
   localparam logic [1:0] DONE  = 2'd2;

   localparam logic [CNT_W-1:0] LAST = CNT_W'(N_SAMPLES - 1);

   logic [1:0]       state_q, state_n;
   logic [ACC_W-1:0] acc_q, acc_n;
   logic [CNT_W-1:0] cnt_q, cnt_n;
   logic             ovf_q, ovf_n;
   logic             err_q, err_n;
   logic [1:0]       sample;
   logic [ACC_W:0]   sum;

   assign sample = {in_carry, in_sum};
   assign sum    = {1'b0, acc_q} + (ACC_W + 1)'(sample);

   always_comb begin
      state_n = state_q;
      acc_n   = acc_q;
      cnt_n   = cnt_q;
      ovf_n   = ovf_q;
      err_n   = err_q;
      if (start) begin
         // restart wins over clr and any coincident sample
         state_n = ACCUM;
         acc_n   = '0;
         cnt_n   = '0;
         ovf_n   = 1'b0;
         err_n   = 1'b0;
      end else begin
         case (state_q)
            IDLE: ;
            ACCUM: begin
               if (in_valid) begin
                  if (sample == 2'b11) begin
                     err_n = 1'b1;
                  end else begin
`ifdef ACC_SAT_EN
                     acc_n = sum[ACC_W] ? '1 : sum[ACC_W-1:0];
`else
                     acc_n = sum[ACC_W-1:0];
`endif
                     if (sum[ACC_W]) ovf_n = 1'b1;
                     cnt_n = cnt_q + CNT_W'(1);
                     if (cnt_q == LAST) state_n = DONE;
                  end
               end
            end
            DONE: begin
               if (clr) state_n = IDLE;
            end
            default: state_n = IDLE;
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         acc_q   <= '0;
         cnt_q   <= '0;
         ovf_q   <= 1'b0;
         err_q   <= 1'b0;
      end else if (ena) begin
         state_q <= state_n;
         acc_q   <= acc_n;
         cnt_q   <= cnt_n;
         ovf_q   <= ovf_n;
         err_q   <= err_n;
      end
   end

   assign acc_out = acc_q;
   assign count   = cnt_q;
   assign busy    = (state_q == ACCUM);
   assign done    = (state_q == DONE);
   assign ovf     = ovf_q;
   assign err     = err_q;

endmodule

// File: tb/tb_ha_result_accumulator.sv
// Directed, table-driven bench for ha_result_accumulator (ACC_W=8 and ACC_W=4 instances).
module tb_ha_result_accumulator;

   logic clk = 1'b0;
   logic rst_n, ena, start, clr, in_valid, in_sum, in_carry;

   logic [7:0] acc_a;
   logic [4:0] cnt_a;
   logic       busy_a, done_a, ovf_a, err_a;
   logic [3:0] acc_b;
   logic [4:0] cnt_b;
   logic       busy_b, done_b, ovf_b, err_b;

   int n_checks = 0;
   int n_fail   = 0;

   always #5 clk = ~clk;

   ha_result_accumulator #(.ACC_W(8), .N_SAMPLES(16)) dut_a (
      .clk(clk), .rst_n(rst_n), .ena(ena), .start(start), .clr(clr),
      .in_valid(in_valid), .in_sum(in_sum), .in_carry(in_carry),
      .acc_out(acc_a), .count(cnt_a), .busy(busy_a), .done(done_a),
      .ovf(ovf_a), .err(err_a)
   );

   ha_result_accumulator #(.ACC_W(4), .N_SAMPLES(16)) dut_b (
      .clk(clk), .rst_n(rst_n), .ena(ena), .start(start), .clr(clr),
      .in_valid(in_valid), .in_sum(in_sum), .in_carry(in_carry),
      .acc_out(acc_b), .count(cnt_b), .busy(busy_b), .done(done_b),
      .ovf(ovf_b), .err(err_b)
   );

   typedef struct {
      logic       ena, start, clr, v, c, s;
      logic [7:0] acc;
      logic [4:0] cnt;
      logic       busy, done, ovf, err;
   } vec_t;

   vec_t tbl[13];

   function automatic vec_t mk(input logic e, input logic st, input logic cl, input logic v,
                               input logic c, input logic s, input logic [7:0] acc,
                               input logic [4:0] cnt, input logic b, input logic d,
                               input logic o, input logic er);
      vec_t r;
      r.ena = e; r.start = st; r.clr = cl; r.v = v; r.c = c; r.s = s;
      r.acc = acc; r.cnt = cnt; r.busy = b; r.done = d; r.ovf = o; r.err = er;
      return r;
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   task automatic chk_a(input string tag, input logic [7:0] acc, input logic [4:0] cnt,
                        input logic b, input logic d, input logic o, input logic er);
      chk({tag, ".acc"},  32'(acc_a),  32'(acc));
      chk({tag, ".cnt"},  32'(cnt_a),  32'(cnt));
      chk({tag, ".busy"}, 32'(busy_a), 32'(b));
      chk({tag, ".done"}, 32'(done_a), 32'(d));
      chk({tag, ".ovf"},  32'(ovf_a),  32'(o));
      chk({tag, ".err"},  32'(err_a),  32'(er));
   endtask

   task automatic drive(input logic e, input logic st, input logic cl, input logic v,
                        input logic c, input logic s);
      ena = e; start = st; clr = cl; in_valid = v; in_carry = c; in_sum = s;
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   initial begin
      rst_n = 1'b0;
      drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      tick();
      chk_a("reset", 8'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
      rst_n = 1'b1;
      tick();
      chk_a("idle", 8'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);

      //              ena st  clr v   c   s    acc   cnt  busy done ovf err
      tbl[0]  = mk(1, 1, 0, 0, 0, 0, 8'd0, 5'd0, 1, 0, 0, 0);
      tbl[1]  = mk(1, 0, 0, 1, 0, 1, 8'd1, 5'd1, 1, 0, 0, 0);
      tbl[2]  = mk(1, 0, 0, 1, 1, 0, 8'd3, 5'd2, 1, 0, 0, 0);
      tbl[3]  = mk(1, 0, 0, 1, 1, 1, 8'd3, 5'd2, 1, 0, 0, 1);
      tbl[4]  = mk(1, 0, 0, 1, 0, 1, 8'd4, 5'd3, 1, 0, 0, 1);
      tbl[5]  = mk(1, 1, 0, 1, 1, 0, 8'd0, 5'd0, 1, 0, 0, 0);
      tbl[6]  = mk(0, 1, 0, 1, 1, 0, 8'd0, 5'd0, 1, 0, 0, 0);
      tbl[7]  = mk(0, 0, 1, 1, 0, 1, 8'd0, 5'd0, 1, 0, 0, 0);
      tbl[8]  = mk(0, 1, 1, 0, 0, 0, 8'd0, 5'd0, 1, 0, 0, 0);
      tbl[9]  = mk(0, 0, 0, 1, 1, 1, 8'd0, 5'd0, 1, 0, 0, 0);
      tbl[10] = mk(1, 0, 0, 1, 0, 0, 8'd0, 5'd1, 1, 0, 0, 0);
      tbl[11] = mk(1, 0, 1, 0, 0, 0, 8'd0, 5'd1, 1, 0, 0, 0);
      tbl[12] = mk(1, 0, 0, 1, 0, 1, 8'd1, 5'd2, 1, 0, 0, 0);

      for (int i = 0; i < 13; i++) begin
         drive(tbl[i].ena, tbl[i].start, tbl[i].clr, tbl[i].v, tbl[i].c, tbl[i].s);
         tick();
         chk_a($sformatf("vec%0d", i), tbl[i].acc, tbl[i].cnt, tbl[i].busy,
               tbl[i].done, tbl[i].ovf, tbl[i].err);
      end

      // full run of 16 x value 2 on both instances
      drive(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
      tick();
      drive(1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
      for (int i = 0; i < 15; i++) tick();
      chk_a("run15", 8'd30, 5'd15, 1'b1, 1'b0, 1'b0, 1'b0);
      tick();
      chk_a("run16", 8'd32, 5'd16, 1'b0, 1'b1, 1'b0, 1'b0);
      chk("w4.cnt", 32'(cnt_b), 32'd16);
      chk("w4.done", 32'(done_b), 32'd1);
      chk("w4.ovf", 32'(ovf_b), 32'd1);
`ifdef ACC_SAT_EN
      chk("w4.acc", 32'(acc_b), 32'd15);
`else
      chk("w4.acc", 32'(acc_b), 32'd0);
`endif
      drive(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1);
      tick();
      chk_a("done_hold", 8'd32, 5'd16, 1'b0, 1'b1, 1'b0, 1'b0);
      drive(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
      tick();
      chk_a("done_clr", 8'd32, 5'd16, 1'b0, 1'b0, 1'b0, 1'b0);
      drive(1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
      tick();
      chk_a("idle_ign", 8'd32, 5'd16, 1'b0, 1'b0, 1'b0, 1'b0);

      // async reset mid-run with acc=5
      drive(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
      tick();
      drive(1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
      tick();
      tick();
      drive(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1);
      tick();
      drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      chk_a("pre_rst", 8'd5, 5'd3, 1'b1, 1'b0, 1'b0, 1'b0);
      #2;
      rst_n = 1'b0;
      #1;
      chk_a("async_rst", 8'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
      tick();
      rst_n = 1'b1;
      tick();
      chk_a("post_rst", 8'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
